// File: rtl/dpcm.sv
// Lossless DPCM encoder: emits the difference between each accepted sample and
// the previous one, plus a decoder-side reconstruction, at most one sample per two cycles.
module dpcm #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W:0]   code,
    output logic              code_valid,
    output logic [DATA_W-1:0] recon
);

    localparam int unsigned CODE_W = DATA_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   pred;
    logic                transfer_c;
    logic [CODE_W-1:0]   diff_c;

    // Next-state logic; the difference is formed one bit wider so it never wraps.
    always_comb begin
        state_next = state;
        transfer_c = in_valid && in_ready;
        diff_c     = CODE_W'({1'b0, data}) - CODE_W'({1'b0, pred});
        case (state)
            IDLE: if (transfer_c) state_next = BUSY;
            BUSY: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_ready held low through reset so it rises on the first edge afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_ready   <= 1'b0;
            code_valid <= 1'b0;
            code       <= '0;
            pred       <= '0;
            recon      <= '0;
        end else begin
            in_ready   <= (state_next == IDLE);
            code_valid <= transfer_c;
            if (transfer_c) begin
                code  <= diff_c;
                pred  <= data;
                recon <= recon + diff_c[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dpcm.sv
// Directed bench for dpcm with DATA_W=4; expected codes computed by hand.
module tb_dpcm;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data;
    logic [4:0] code;
    logic       code_valid;
    logic [3:0] recon;

    int checks;
    int failures;

    dpcm #(.DATA_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data       (data),
        .code       (code),
        .code_valid (code_valid),
        .recon      (recon)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
    endtask

    initial begin
        int xfers;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        data     = 4'h0;

        // Reset state before any clock edge
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_code_valid", 32'(code_valid), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_recon", 32'(recon), 32'd0);
        #9;
        reset = 1'b0;
        step();
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Transfer 5 then 3
        in_valid = 1'b1; data = 4'h5;
        step();
        in_valid = 1'b0;
        chk("s1_code", 32'(code), 32'h05);
        chk("s1_code_valid", 32'(code_valid), 32'd1);
        chk("s1_in_ready", 32'(in_ready), 32'd0);
        chk("s1_recon", 32'(recon), 32'h5);
        step();
        chk("s1_idle_valid", 32'(code_valid), 32'd0);
        chk("s1_idle_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; data = 4'h3;
        step();
        in_valid = 1'b0;
        chk("s2_code", 32'(code), 32'h1E);
        chk("s2_recon", 32'(recon), 32'h3);
        chk("s2_code_valid", 32'(code_valid), 32'd1);
        step();
        chk("s2_idle_valid", 32'(code_valid), 32'd0);
        chk("s2_idle_ready", 32'(in_ready), 32'd1);
        chk("s2_code_hold", 32'(code), 32'h1E);

        // Extremes from pred=0
        do_reset();
        chk("s3_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; data = 4'hF;
        step();
        in_valid = 1'b0;
        chk("s3_code_pos15", 32'(code), 32'h0F);
        chk("s3_recon_f", 32'(recon), 32'hF);
        step();
        in_valid = 1'b1; data = 4'h0;
        step();
        in_valid = 1'b0;
        chk("s3_code_neg15", 32'(code), 32'h11);
        chk("s3_recon_0", 32'(recon), 32'h0);
        step();

        // in_valid held high: transfers on alternating edges
        xfers = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 4'(i / 2 + 1);
            step();
            chk("s4_code_valid", 32'(code_valid), 32'((i % 2) == 0));
            if ((i % 2) == 0) begin
                chk("s4_code", 32'(code), 32'h01);
                chk("s4_recon", 32'(recon), 32'(i / 2 + 1));
            end else begin
                chk("s4_ready", 32'(in_ready), 32'd1);
            end
            if (code_valid) xfers++;
        end
        in_valid = 1'b0;
        chk("s4_xfers", 32'(xfers), 32'd4);

        // Reset mid-BUSY
        in_valid = 1'b1; data = 4'h9;
        step();
        in_valid = 1'b0;
        chk("s5_code", 32'(code), 32'h05);
        chk("s5_code_valid", 32'(code_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("s5_rst_valid", 32'(code_valid), 32'd0);
        chk("s5_rst_ready", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b0;
        step();
        chk("s5_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; data = 4'h2;
        step();
        in_valid = 1'b0;
        chk("s5_code_after", 32'(code), 32'h02);
        chk("s5_recon_after", 32'(recon), 32'h2);
        step();

        // Data toggling with in_valid low has no effect
        for (int i = 0; i < 5; i++) begin
            data = (i % 2 == 0) ? 4'hA : 4'h5;
            step();
            chk("s6_no_valid", 32'(code_valid), 32'd0);
            chk("s6_recon", 32'(recon), 32'h2);
            chk("s6_code", 32'(code), 32'h02);
        end
        // Same sample again differences to zero, proving pred stayed at 2
        in_valid = 1'b1; data = 4'h2;
        step();
        in_valid = 1'b0;
        chk("s6_pred_kept", 32'(code), 32'h00);
        chk("s6_recon_kept", 32'(recon), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
